// File: rtl/repeated_subtraction_divider.sv
// repeated_subtraction_divider: unsigned divide by repeated subtraction, operands loaded over a shared data_in bus.
// Optional abort input is enabled by defining DIVIDER_ABORT_EN.
module repeated_subtraction_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
`ifdef DIVIDER_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_d;
    logic             r_dbz;
    logic             w_abort;
    logic             w_ge;

`ifdef DIVIDER_ABORT_EN
    assign w_abort = abort && (r_state == LOAD_B || r_state == CHECK);
`else
    assign w_abort = 1'b0;
`endif
    assign w_ge = r_r >= r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_dbz   <= 1'b0;
        end else if (w_abort) begin
            r_state <= IDLE;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_r     <= data_in;
                    r_q     <= '0;
                    r_dbz   <= 1'b0;
                    r_state <= LOAD_B;
                end
                LOAD_B: begin
                    r_d     <= data_in;
                    r_state <= CHECK;
                end
                CHECK: if (r_d == '0) begin
                    r_dbz   <= 1'b1;
                    r_q     <= '1;
                    r_state <= DONE;
                end else if (w_ge) begin
                    r_r <= r_r - r_d;
                    r_q <= r_q + WIDTH'(1);
                end else begin
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign quotient  = r_q;
    assign remainder = r_r;
    assign dbz       = r_dbz;
endmodule
